// File: rtl/nmi_pkg.sv
// Shared types and constants for the two-requester NMI arbiter.
package nmi_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } nmi_state_e;

  localparam int unsigned NMI_ADDR_W = 32;
  localparam int unsigned NMI_DATA_W = 32;
  localparam int unsigned NMI_STRB_W = 4;
  localparam int unsigned NMI_CNT_W  = 8;

  localparam logic [NMI_DATA_W-1:0] NMI_ERR_RDATA = 32'hBADC_0FFE;

endpackage

// File: rtl/nmi_rr_pick.sv
// Two-input round-robin picker: on a tie the requester that did not own the
// port last time wins; a lone requester always wins.
module nmi_rr_pick (
  input  logic [1:0] valid,
  input  logic       last_owner,
  output logic [1:0] grant
);

  // One-hot grant from the current valids and the last owner.
  always_comb begin
    grant = 2'b00;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_owner ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/nmi_arbiter.sv
// Arbitrates two NMI requesters onto one shared NMI port (toward an APB
// bridge). Handshake: a requester holds mN_valid_i until mN_ready_o pulses for
// one cycle; the shared port holds s_valid_o until s_ready_i is seen, and
// s_valid_o always returns to 0 for at least one IDLE cycle between transfers.
// A transfer that waits TIMEOUT_CYCLES busy cycles is completed with ERR_RDATA.
module nmi_arbiter
  import nmi_pkg::*;
#(
  parameter int unsigned           TIMEOUT_CYCLES = 255,
  parameter logic [NMI_DATA_W-1:0] ERR_RDATA      = NMI_ERR_RDATA
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_valid_i,
  output logic                  m0_ready_o,
  input  logic [NMI_ADDR_W-1:0] m0_addr_i,
  input  logic [NMI_DATA_W-1:0] m0_wdata_i,
  input  logic [NMI_STRB_W-1:0] m0_wstrb_i,
  output logic [NMI_DATA_W-1:0] m0_rdata_o,
  input  logic                  m1_valid_i,
  output logic                  m1_ready_o,
  input  logic [NMI_ADDR_W-1:0] m1_addr_i,
  input  logic [NMI_DATA_W-1:0] m1_wdata_i,
  input  logic [NMI_STRB_W-1:0] m1_wstrb_i,
  output logic [NMI_DATA_W-1:0] m1_rdata_o,
  output logic                  s_valid_o,
  output logic [NMI_ADDR_W-1:0] s_addr_o,
  output logic [NMI_DATA_W-1:0] s_wdata_o,
  output logic [NMI_STRB_W-1:0] s_wstrb_o,
  input  logic                  s_ready_i,
  input  logic [NMI_DATA_W-1:0] s_rdata_i,
  output logic [1:0]            grant_o,
  output logic                  timeout_o,
  output nmi_state_e            state_o
);

  localparam logic [NMI_CNT_W-1:0] TO_LAST = NMI_CNT_W'(TIMEOUT_CYCLES - 1);

  nmi_state_e           state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_q, last_d;
  logic [NMI_CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]           pick_grant;
  logic                 busy, own_valid, done_ok, to_hit, complete;

  nmi_rr_pick u_pick (
    .valid      ({m1_valid_i, m0_valid_i}),
    .last_owner (last_q),
    .grant      (pick_grant)
  );

  // Reset is folded into busy so a transfer in flight produces no pulse while
  // rst_i is high, not even in the cycle before the reset edge.
  assign busy      = (state_q == BUSY) && !rst_i;
  assign own_valid = owner_q ? m1_valid_i : m0_valid_i;
  assign done_ok   = busy && own_valid && s_ready_i;
  assign to_hit    = busy && own_valid && !s_ready_i && (cnt_q == TO_LAST);
  assign complete  = done_ok || to_hit;
  assign state_o   = state_q;

  // State, owner, last-owner and timeout counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: grab an owner in IDLE, leave BUSY on completion, timeout or
  // a dropped owner valid (the latter keeps the last owner untouched).
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|pick_grant) begin
          state_d = BUSY;
          owner_d = pick_grant[1];
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (!own_valid) begin
          state_d = IDLE;
        end else if (complete) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output steering: shared port follows the owner while BUSY, completion
  // data goes back only to the owner in its completion cycle.
  always_comb begin
    s_valid_o  = 1'b0;
    s_addr_o   = '0;
    s_wdata_o  = '0;
    s_wstrb_o  = '0;
    grant_o    = 2'b00;
    timeout_o  = 1'b0;
    m0_ready_o = 1'b0;
    m1_ready_o = 1'b0;
    m0_rdata_o = '0;
    m1_rdata_o = '0;
    if (busy) begin
      grant_o   = owner_q ? 2'b10 : 2'b01;
      s_valid_o = own_valid;
      s_addr_o  = owner_q ? m1_addr_i  : m0_addr_i;
      s_wdata_o = owner_q ? m1_wdata_i : m0_wdata_i;
      s_wstrb_o = owner_q ? m1_wstrb_i : m0_wstrb_i;
      timeout_o = to_hit;
      if (complete) begin
        if (owner_q) begin
          m1_ready_o = 1'b1;
          m1_rdata_o = done_ok ? s_rdata_i : ERR_RDATA;
        end else begin
          m0_ready_o = 1'b1;
          m0_rdata_o = done_ok ? s_rdata_i : ERR_RDATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_nmi_arbiter.sv
// Bench for nmi_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level reference model.
module tb_nmi_arbiter;
  import nmi_pkg::*;

  localparam int unsigned TO = 4;
  localparam logic [31:0] ERR = 32'hBADC_0FFE;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m_valid [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_wstrb [2];
  logic        m_ready [2];
  logic [31:0] m_rdata [2];
  logic        s_valid, s_ready, timeout;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;
  nmi_state_e  dut_state;

  nmi_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_valid_i(m_valid[0]), .m0_ready_o(m_ready[0]), .m0_addr_i(m_addr[0]),
    .m0_wdata_i(m_wdata[0]), .m0_wstrb_i(m_wstrb[0]), .m0_rdata_o(m_rdata[0]),
    .m1_valid_i(m_valid[1]), .m1_ready_o(m_ready[1]), .m1_addr_i(m_addr[1]),
    .m1_wdata_i(m_wdata[1]), .m1_wstrb_i(m_wstrb[1]), .m1_rdata_o(m_rdata[1]),
    .s_valid_o(s_valid), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb),
    .s_ready_i(s_ready), .s_rdata_i(s_rdata),
    .grant_o(grant), .timeout_o(timeout), .state_o(dut_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h @%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
    m_valid[i] = v;
    m_addr[i]  = a;
    m_wdata[i] = wd;
    m_wstrb[i] = ws;
  endtask

  task automatic set_slave(input logic r, input logic [31:0] d);
    s_ready = r;
    s_rdata = d;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Model: which requester holds the port (-1 = none), who held it last,
  // and how many busy cycles the current transfer has been waiting (1-based).
  int m_owner = -1;
  int m_last  = 1;
  int m_age   = 0;
  bit chk_en  = 1'b0;
  bit sb_en   = 1'b0;
  logic [32:0] exp_q[$];   // {owner, rdata} expected completions

  logic [1:0]  e_grant;
  logic        e_sv, e_to, fin;
  logic [31:0] e_addr, e_wd;
  logic [3:0]  e_ws;
  logic        e_rdy [2];
  logic [31:0] e_rd  [2];
  logic [32:0] sb_e;

  always @(negedge clk) begin
    if (chk_en) begin
      e_grant = 2'b00; e_sv = 1'b0; e_to = 1'b0; fin = 1'b0;
      e_addr = '0; e_wd = '0; e_ws = '0;
      e_rdy[0] = 1'b0; e_rdy[1] = 1'b0; e_rd[0] = '0; e_rd[1] = '0;
      if (!rst && m_owner >= 0) begin
        e_grant = (m_owner == 0) ? 2'b01 : 2'b10;
        e_sv    = m_valid[m_owner];
        e_addr  = m_addr[m_owner];
        e_wd    = m_wdata[m_owner];
        e_ws    = m_wstrb[m_owner];
        if (m_valid[m_owner]) begin
          if (s_ready) begin
            e_rdy[m_owner] = 1'b1; e_rd[m_owner] = s_rdata; fin = 1'b1;
          end else if (m_age == TO) begin
            e_rdy[m_owner] = 1'b1; e_rd[m_owner] = ERR; e_to = 1'b1; fin = 1'b1;
          end
        end
      end
      check("grant",    {30'd0, grant},       {30'd0, e_grant});
      check("s_valid",  {31'd0, s_valid},     {31'd0, e_sv});
      check("s_addr",   s_addr,               e_addr);
      check("s_wdata",  s_wdata,              e_wd);
      check("s_wstrb",  {28'd0, s_wstrb},     {28'd0, e_ws});
      check("timeout",  {31'd0, timeout},     {31'd0, e_to});
      check("m0_ready", {31'd0, m_ready[0]},  {31'd0, e_rdy[0]});
      check("m0_rdata", m_rdata[0],           e_rd[0]);
      check("m1_ready", {31'd0, m_ready[1]},  {31'd0, e_rdy[1]});
      check("m1_rdata", m_rdata[1],           e_rd[1]);

      if (sb_en) begin
        for (int i = 0; i < 2; i++) begin
          if (m_ready[i] === 1'b1) begin
            if (exp_q.size() == 0) begin
              check("sb_unexpected", 32'(i), 32'hFFFF_FFFF);
            end else begin
              sb_e = exp_q.pop_front();
              check("sb_owner", 32'(i), {31'd0, sb_e[32]});
              check("sb_rdata", m_rdata[i], sb_e[31:0]);
            end
          end
        end
      end

      if (rst) begin
        m_owner = -1; m_last = 1;
      end else if (m_owner < 0) begin
        if (m_valid[0] && m_valid[1]) m_owner = 1 - m_last;
        else if (m_valid[0])          m_owner = 0;
        else if (m_valid[1])          m_owner = 1;
        m_age = 1;
      end else if (!m_valid[m_owner]) begin
        m_owner = -1;
      end else if (fin) begin
        m_last  = m_owner;
        m_owner = -1;
      end else begin
        m_age++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    set_slave(0, 0);
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    sb_en  = 1'b1;
    reset_dut();

    // m0 read, slave answers on busy cycle 3
    set_req(0, 1, 32'h0000_0010, 32'h0, 4'h0);
    tick(); tick(); tick();
    set_slave(1, 32'h1234_5678); exp_q.push_back({1'b0, 32'h1234_5678});
    tick();
    set_req(0, 0, 0, 0, 0); set_slave(0, 0);
    tick();
    check("sb_drain_read", 32'(exp_q.size()), 32'd0);

    // both valid from reset: alternation m0, m1, m0, m1
    reset_dut();
    set_req(0, 1, 32'h100, 32'h1, 4'hF);
    set_req(1, 1, 32'h200, 32'h2, 4'h1);
    for (int k = 0; k < 4; k++) begin
      tick();
      tick();
      set_slave(1, 32'hC0DE_0000 + 32'(k));
      exp_q.push_back({k[0], 32'hC0DE_0000 + 32'(k)});
      tick();
      set_slave(0, 0);
    end
    set_req(0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0);
    tick();
    check("sb_drain_rr", 32'(exp_q.size()), 32'd0);

    // m1 write never answered: forced completion on busy cycle 4
    set_req(1, 1, 32'h40, 32'hCAFE_F00D, 4'b0011);
    tick(); tick(); tick(); tick();
    exp_q.push_back({1'b1, ERR});
    tick();
    set_req(1, 0, 0, 0, 0);
    tick();
    check("sb_drain_timeout", 32'(exp_q.size()), 32'd0);

    // slave answers exactly on the timeout cycle: normal completion wins
    set_req(0, 1, 32'h80, 32'h0, 4'h0);
    tick(); tick(); tick(); tick();
    set_slave(1, 32'hA5A5_A5A5); exp_q.push_back({1'b0, 32'hA5A5_A5A5});
    tick();
    set_req(0, 0, 0, 0, 0); set_slave(0, 0);
    tick();
    check("sb_drain_race", 32'(exp_q.size()), 32'd0);

    // reset on busy cycle 2 aborts silently; m0 wins the first tie after it
    set_req(0, 1, 32'h10, 32'h0, 4'h0);
    tick(); tick();
    rst = 1'b1; set_slave(1, 32'hDEAD_BEEF);
    tick();
    rst = 1'b0; set_slave(0, 0);
    set_req(1, 1, 32'h20, 32'h0, 4'h0);
    tick();
    set_slave(1, 32'h0000_0A0A); exp_q.push_back({1'b0, 32'h0000_0A0A});
    tick();
    set_slave(0, 0); set_req(0, 0, 0, 0, 0);
    tick();
    set_slave(1, 32'h0000_0B0B); exp_q.push_back({1'b1, 32'h0000_0B0B});
    tick();
    set_slave(0, 0); set_req(1, 0, 0, 0, 0);
    tick();
    check("sb_drain_reset", 32'(exp_q.size()), 32'd0);

    // m1 drops valid on busy cycle 1 while m0 waits: no pulse, m0 follows
    set_req(1, 1, 32'h30, 32'h0, 4'h0);
    tick();
    set_req(1, 0, 0, 0, 0);
    set_req(0, 1, 32'h34, 32'h0, 4'h0);
    tick(); tick();
    set_slave(1, 32'h0000_5555); exp_q.push_back({1'b0, 32'h0000_5555});
    tick();
    set_slave(0, 0); set_req(0, 0, 0, 0, 0);
    tick();
    check("sb_drain_drop", 32'(exp_q.size()), 32'd0);

    // random traffic, checked by the model only
    sb_en = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!m_valid[i]) begin
          if ($urandom_range(0, 2) == 0)
            set_req(i, 1, $urandom, $urandom, 4'($urandom_range(0, 15)));
        end else if ($urandom_range(0, 24) == 0) begin
          m_valid[i] = 1'b0;
        end
      end
      set_slave($urandom_range(0, 4) == 0, $urandom);
      tick();
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
